branch_resolve_unit: RTL
========================

BRANCH_RESOLVE_UNIT -- requirements
Module: branch_resolve_unit

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset, with ports named clk_i and rst_i.
REQ-002 The block SHALL have parameter ADDR_W, default 32: PC and target width.
REQ-003 The block SHALL have parameter CNT_W, default 32: performance counter width.
REQ-004 Ports SHALL be exactly:
  - clk_i  in  1  clock
  - rst_i  in  1  async reset, active-high
  - id_branch_i  in  1  conditional branch in ID
  - id_pred_i  in  1  prediction carried with the ID instruction (1 = taken)
  - id_pc_i  in  ADDR_W  PC of the ID instruction
  - id_target_i  in  ADDR_W  branch target computed in ID
  - stall_i  in  1  load-use stall: ID holds, bubble into EX
  - ex_taken_i  in  1  actual branch outcome, valid when the EX entry holds a branch
  - id_redirect_o  out  1  predicted-taken redirect from ID
  - id_redirect_pc_o  out  ADDR_W  equals id_target_i
  - mispredict_o  out  1  EX branch outcome differs from its stored prediction
  - redirect_pc_o  out  ADDR_W  correct-path PC on mispredict
  - flush_o  out  1  flush IF/ID and ID/EX
  - upd_branch_o  out  1  predictor update strobe (predictor Branch_i)
  - upd_pred_o  out  1  stored prediction (predictor update_i)
  - upd_result_o  out  1  actual outcome (predictor result_i)
  - branch_cnt_o  out  CNT_W  resolved branches (macro-dependent)
  - mispred_cnt_o  out  CNT_W  mispredictions (macro-dependent)

Function
REQ-005 The block SHALL keep one EX entry {valid, pred, pc_plus4, target}, with pc_plus4 = id_pc_i + 4 modulo 2^ADDR_W.
REQ-006 On each clock edge the entry SHALL load from ID when id_branch_i=1, stall_i=0, mispredict_o=0, and state=NORMAL; otherwise valid SHALL be cleared (bubble).
REQ-007 mispredict_o SHALL be combinational: valid & (pred != ex_taken_i), asserted in the same cycle the branch is in EX.
REQ-008 redirect_pc_o SHALL be target when ex_taken_i=1, pc_plus4 when ex_taken_i=0, and 0 when mispredict_o=0.
REQ-009 flush_o SHALL equal mispredict_o.
REQ-010 The predictor update outputs SHALL be: upd_branch_o=valid, upd_pred_o=pred, upd_result_o=ex_taken_i, with all three 0 when valid=0.
REQ-011 id_redirect_o SHALL be id_branch_i & id_pred_i & ~stall_i & ~mispredict_o, and SHALL be 0 in state RECOVER.
REQ-012 The FSM SHALL have two states, NORMAL and RECOVER:
  - NORMAL -> RECOVER when mispredict_o=1.
  - RECOVER -> NORMAL unconditionally after 1 cycle.
  - In RECOVER, ID inputs SHALL be ignored (wrong-path slot).
REQ-013 When stall_i=1 and mispredict_o=1 in the same cycle, mispredict SHALL take priority: flush SHALL occur and the EX entry SHALL clear.
REQ-014 A stall SHALL NOT block resolution of the entry already in EX.
REQ-015 Back-to-back branches SHALL resolve one per cycle with no bubble when there is no mispredict.

Reset
REQ-016 While rst_i=1:
  - valid=0 and state=NORMAL.
  - All outputs SHALL be 0, including both counters.
REQ-017 Reset asserted mid-resolution SHALL drop the pending entry with no update strobe.

Configuration
REQ-018 With BRU_PERF_CNT_EN defined, branch_cnt_o SHALL increment on each upd_branch_o=1 cycle and mispred_cnt_o on each mispredict_o=1 cycle, both saturating at 2^CNT_W-1.
REQ-019 With BRU_PERF_CNT_EN undefined, both counter outputs SHALL be tied to 0 and no counter flops SHALL exist.

Structure
REQ-020 Package bru_pkg SHALL hold the state enum (NORMAL, RECOVER) and the constant PC_STEP=4.
REQ-021 The counters SHALL be a sub-module, bru_perf_cnt, instantiated only under BRU_PERF_CNT_EN.

Verification
REQ-022 The bench SHALL cover at least these directed scenarios:
  - Correct prediction: branch, pc=0x100, target=0x140, pred=1; next cycle ex_taken=1 -> mispredict_o=0, upd_branch_o=1, upd_pred_o=1, upd_result_o=1.
  - Mispredict not-taken: same branch, ex_taken=0 -> mispredict_o=1, flush_o=1, redirect_pc_o=0x104; next cycle state=RECOVER and id_redirect_o=0.
  - Mispredict taken: pred=0, ex_taken=1, target=0x80 -> redirect_pc_o=0x80; a branch in ID that cycle is not captured.
  - Stall with mispredict: stall_i=1 together with a mispredict -> flush_o=1; following cycle upd_branch_o=0.
  - Wrap-around: pc=0xFFFFFFFC, pred=1, ex_taken=0 -> redirect_pc_o=0x00000000.
  - Reset mid-flight plus counters (macro on): 3 branches with 1 mispredict -> branch_cnt_o=3, mispred_cnt_o=1; rst_i pulse -> both 0, upd_branch_o=0.

Source files
------------

// File: rtl/bru_pkg.sv
// Shared types and constants for the branch resolve unit.
package bru_pkg;

    typedef enum logic {
        NORMAL  = 1'b0,
        RECOVER = 1'b1
    } bru_state_e;

    localparam int unsigned PC_STEP = 4;

endpackage

// File: rtl/branch_resolve_unit_if.sv
// Signal bundle between the decode/execute pipeline and the branch resolve unit.
interface branch_resolve_unit_if #(
    parameter int ADDR_W = 32,
    parameter int CNT_W  = 32
);
    logic              id_branch_i;
    logic              id_pred_i;
    logic [ADDR_W-1:0] id_pc_i;
    logic [ADDR_W-1:0] id_target_i;
    logic              stall_i;
    logic              ex_taken_i;
    logic              id_redirect_o;
    logic [ADDR_W-1:0] id_redirect_pc_o;
    logic              mispredict_o;
    logic [ADDR_W-1:0] redirect_pc_o;
    logic              flush_o;
    logic              upd_branch_o;
    logic              upd_pred_o;
    logic              upd_result_o;
    logic [CNT_W-1:0]  branch_cnt_o;
    logic [CNT_W-1:0]  mispred_cnt_o;

    // Pipeline side: drives ID/EX information, consumes redirects and updates.
    modport master (
        output id_branch_i, id_pred_i, id_pc_i, id_target_i, stall_i, ex_taken_i,
        input  id_redirect_o, id_redirect_pc_o, mispredict_o, redirect_pc_o,
        input  flush_o, upd_branch_o, upd_pred_o, upd_result_o,
        input  branch_cnt_o, mispred_cnt_o
    );

    modport slave (
        input  id_branch_i, id_pred_i, id_pc_i, id_target_i, stall_i, ex_taken_i,
        output id_redirect_o, id_redirect_pc_o, mispredict_o, redirect_pc_o,
        output flush_o, upd_branch_o, upd_pred_o, upd_result_o,
        output branch_cnt_o, mispred_cnt_o
    );
endinterface

// File: rtl/bru_perf_cnt.sv
// Saturating resolved-branch and misprediction counters.
module bru_perf_cnt #(
    parameter int CNT_W = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             branch_inc_i,
    input  logic             mispred_inc_i,
    output logic [CNT_W-1:0] branch_cnt_o,
    output logic [CNT_W-1:0] mispred_cnt_o
);

    logic [CNT_W-1:0] branch_cnt_q, branch_cnt_d;
    logic [CNT_W-1:0] mispred_cnt_q, mispred_cnt_d;

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        branch_cnt_d  = branch_cnt_q;
        mispred_cnt_d = mispred_cnt_q;
        if (branch_inc_i && (branch_cnt_q != '1))
            branch_cnt_d = branch_cnt_q + 1'b1;
        if (mispred_inc_i && (mispred_cnt_q != '1))
            mispred_cnt_d = mispred_cnt_q + 1'b1;
    end

    // NOTE: state registers use non-blocking assignment only.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            branch_cnt_q  <= '0;
            mispred_cnt_q <= '0;
        end else begin
            branch_cnt_q  <= branch_cnt_d;
            mispred_cnt_q <= mispred_cnt_d;
        end
    end

    assign branch_cnt_o  = branch_cnt_q;
    assign mispred_cnt_o = mispred_cnt_q;

endmodule

// File: rtl/branch_resolve_unit.sv
// Resolves the conditional branch held in EX against its prediction and drives
// redirect/flush/predictor-update. Define BRU_PERF_CNT_EN to add perf counters.
module branch_resolve_unit
    import bru_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int CNT_W  = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              id_branch_i,
    input  logic              id_pred_i,
    input  logic [ADDR_W-1:0] id_pc_i,
    input  logic [ADDR_W-1:0] id_target_i,
    input  logic              stall_i,
    input  logic              ex_taken_i,
    output logic              id_redirect_o,
    output logic [ADDR_W-1:0] id_redirect_pc_o,
    output logic              mispredict_o,
    output logic [ADDR_W-1:0] redirect_pc_o,
    output logic              flush_o,
    output logic              upd_branch_o,
    output logic              upd_pred_o,
    output logic              upd_result_o,
    output logic [CNT_W-1:0]  branch_cnt_o,
    output logic [CNT_W-1:0]  mispred_cnt_o
);

    bru_state_e        state_q, state_d;
    logic              valid_q, valid_d;
    logic              pred_q, pred_d;
    logic [ADDR_W-1:0] pc_plus4_q, pc_plus4_d;
    logic [ADDR_W-1:0] target_q, target_d;
    logic              load_en;

    assign mispredict_o = valid_q & (pred_q != ex_taken_i);
    assign flush_o      = mispredict_o;
    assign redirect_pc_o = !mispredict_o ? '0 : (ex_taken_i ? target_q : pc_plus4_q);

    assign upd_branch_o = valid_q;
    assign upd_pred_o   = valid_q & pred_q;
    assign upd_result_o = valid_q & ex_taken_i;

    // The ID slot right after a mispredict is wrong-path; reset also forces it quiet.
    assign id_redirect_o    = ~rst_i & (state_q == NORMAL) & id_branch_i & id_pred_i
                              & ~stall_i & ~mispredict_o;
    assign id_redirect_pc_o = rst_i ? '0 : id_target_i;

    assign load_en = id_branch_i & ~stall_i & ~mispredict_o & (state_q == NORMAL);

    always_comb begin
        valid_d    = load_en;
        pred_d     = pred_q;
        pc_plus4_d = pc_plus4_q;
        target_d   = target_q;
        if (load_en) begin
            pred_d     = id_pred_i;
            pc_plus4_d = id_pc_i + ADDR_W'(PC_STEP);
            target_d   = id_target_i;
        end
        state_d = (state_q == NORMAL && mispredict_o) ? RECOVER : NORMAL;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= NORMAL;
            valid_q    <= 1'b0;
            pred_q     <= 1'b0;
            pc_plus4_q <= '0;
            target_q   <= '0;
        end else begin
            state_q    <= state_d;
            valid_q    <= valid_d;
            pred_q     <= pred_d;
            pc_plus4_q <= pc_plus4_d;
            target_q   <= target_d;
        end
    end

`ifdef BRU_PERF_CNT_EN
    bru_perf_cnt #(
        .CNT_W (CNT_W)
    ) u_perf_cnt (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .branch_inc_i  (upd_branch_o),
        .mispred_inc_i (mispredict_o),
        .branch_cnt_o  (branch_cnt_o),
        .mispred_cnt_o (mispred_cnt_o)
    );
`else
    assign branch_cnt_o  = '0;
    assign mispred_cnt_o = '0;
`endif

endmodule
